// File: rtl/decode_issue_pkg.sv
// Shared core definitions: RV32I opcodes, ALU function codes (funct3) and funct7 values.
// Used by decode/issue and by the ALU so both agree on the function encoding.
package decode_issue_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [0:0] {
    SB_IDLE    = 1'b0,
    SB_PENDING = 1'b1
  } sb_state_e;

  // Only ADD/SUB and SRL/SRA have an alternate (funct7=0100000) form.
  function automatic logic f3_has_alt(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SRL);
  endfunction

  function automatic logic f3_is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL);
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// 32x32 integer register file: x0 hardwired to zero, two read ports with
// same-cycle write bypass, async active-low clear of every register.
module regfile
  import decode_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [4:0]      i_wrd,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wrd != 5'd0)) begin
      r_regs[i_wrd] <= i_wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = r_regs[idx];
    if (idx == 5'd0) begin
      v = '0;
    end else if (i_we && (i_wrd == idx)) begin
      v = i_wd;
    end
    return v;
  endfunction

  assign o_rs1_data = read_port(i_rs1);
  assign o_rs2_data = read_port(i_rs2);

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue for OP, OP-IMM and LUI with a single-entry scoreboard that
// holds issue until the outstanding destination is written back.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  output logic [XLEN-1:0] lhs,
  output logic [XLEN-1:0] rhs,
  output logic [2:0]      func,
  output logic            alt,
  output logic [4:0]      out_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  // state      | meaning
  // SB_IDLE    | no result outstanding; any instruction may issue
  // SB_PENDING | r_pending_rd awaits writeback; issue only in the release cycle

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  logic            w_legal;
  logic [XLEN-1:0] w_lhs;
  logic [XLEN-1:0] w_rhs;
  logic [2:0]      w_func;
  logic            w_alt;

  logic            w_release;
  logic            w_accept;
  logic            w_issue;

  sb_state_e       r_state;
  logic [4:0]      r_pending_rd;
  logic            r_out_valid;
  logic            r_illegal;
  logic [XLEN-1:0] r_lhs;
  logic [XLEN-1:0] r_rhs;
  logic [2:0]      r_func;
  logic            r_alt;
  logic [4:0]      r_out_rd;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_f3     = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_f7     = instr[31:25];

  regfile #(.XLEN(XLEN)) u_regfile (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (wb_en),
    .i_wrd      (wb_rd),
    .i_wd       (wb_data)
  );

  always_comb begin
    w_legal = 1'b0;
    w_func  = F3_ADD;
    w_alt   = 1'b0;
    w_lhs   = w_rs1_data;
    w_rhs   = w_rs2_data;
    case (w_opcode)
      OPC_OP: begin
        w_legal = (w_f7 == F7_BASE) || ((w_f7 == F7_ALT) && f3_has_alt(w_f3));
        w_func  = w_f3;
        w_alt   = f3_has_alt(w_f3) && instr[30];
      end
      OPC_OP_IMM: begin
        w_legal = 1'b1;
        w_func  = w_f3;
        if (f3_is_shift(w_f3)) begin
          w_rhs = {{(XLEN-5){1'b0}}, instr[24:20]};
          w_alt = (w_f3 == F3_SRL) && instr[30];
        end else begin
          w_rhs = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_lhs   = '0;
        w_rhs   = {instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Release and re-issue share a cycle; the regfile bypass supplies the operand.
  assign w_release = wb_en && (wb_rd == r_pending_rd);
  assign in_ready  = (r_state == SB_IDLE) || w_release;
  assign w_accept  = in_valid && in_ready;
  assign w_issue   = w_accept && w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SB_IDLE;
      r_pending_rd <= 5'd0;
      r_out_valid  <= 1'b0;
      r_illegal    <= 1'b0;
      r_lhs        <= '0;
      r_rhs        <= '0;
      r_func       <= 3'd0;
      r_alt        <= 1'b0;
      r_out_rd     <= 5'd0;
    end else begin
      r_out_valid <= w_issue;
      r_illegal   <= w_accept && !w_legal;
      if (w_issue) begin
        r_lhs    <= w_lhs;
        r_rhs    <= w_rhs;
        r_func   <= w_func;
        r_alt    <= w_alt;
        r_out_rd <= w_rd;
      end
      case (r_state)
        SB_IDLE: begin
          if (w_issue && (w_rd != 5'd0)) begin
            r_state      <= SB_PENDING;
            r_pending_rd <= w_rd;
          end
        end
        SB_PENDING: begin
          if (w_release) begin
            if (w_issue && (w_rd != 5'd0)) begin
              r_pending_rd <= w_rd;
            end else begin
              r_state <= SB_IDLE;
            end
          end
        end
        default: r_state <= SB_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign lhs       = r_lhs;
  assign rhs       = r_rhs;
  assign func      = r_func;
  assign alt       = r_alt;
  assign out_rd    = r_out_rd;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: decode vector table, hand-written
// scoreboard/bypass/reset sequences and randomized traffic against a reference model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [2:0]  func;
  logic        alt;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic        m_busy;
  logic [4:0]  m_busy_rd;

  always #5 clk = ~clk;

  decode_issue #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .lhs       (lhs),
    .rhs       (rhs),
    .func      (func),
    .alt       (alt),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy    = 1'b0;
    m_busy_rd = 5'd0;
  endtask

  function automatic logic [31:0] rd_val(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && (wrd == idx)) return wd;
    return m_regs[idx];
  endfunction

  task automatic model_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                              output logic lg, output logic [31:0] l, output logic [31:0] r,
                              output logic [2:0] f, output logic al);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    lg = 1'b0; l = a; r = b; f = f3; al = 1'b0;
    if (op == 7'h33) begin
      lg = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      al = (f7 == 7'h20);
    end else if (op == 7'h13) begin
      lg = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r  = 32'(ins[24:20]);
        al = (f3 == 3'd5) && ins[30];
      end else begin
        r = {{20{ins[31]}}, ins[31:20]};
      end
    end else if (op == 7'h37) begin
      lg = 1'b1;
      l  = 32'h0;
      r  = {ins[31:12], 12'h000};
      f  = 3'd0;
    end
  endtask

  // One clock: drive at negedge, check in_ready, clock, check registered outputs.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd);
    logic exp_rdy, acc, lg, ealt;
    logic [31:0] el, er;
    logic [2:0]  ef;
    in_valid = v; instr = ins; wb_en = we; wb_rd = wrd; wb_data = wd;
    #1;
    exp_rdy = !m_busy || (we && (wrd == m_busy_rd));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    model_decode(ins, rd_val(ins[19:15], we, wrd, wd), rd_val(ins[24:20], we, wrd, wd),
                 lg, el, er, ef, ealt);
    @(posedge clk);
    if (we && (wrd != 5'd0)) m_regs[wrd] = wd;
    if (m_busy && we && (wrd == m_busy_rd)) m_busy = 1'b0;
    if (acc && lg && (ins[11:7] != 5'd0)) begin
      m_busy    = 1'b1;
      m_busy_rd = ins[11:7];
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(acc && lg));
    chk("illegal", 32'(illegal), 32'(acc && !lg));
    if (acc && lg) begin
      chk("lhs", lhs, el);
      chk("rhs", rhs, er);
      chk("func", 32'(func), 32'(ef));
      chk("alt", 32'(alt), 32'(ealt));
      chk("out_rd", 32'(out_rd), 32'(ins[11:7]));
    end
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_ready"}, 32'(in_ready), 32'h1);
    chk({n, "_valid"}, 32'(out_valid), 32'h0);
    chk({n, "_illegal"}, 32'(illegal), 32'h0);
    chk({n, "_lhs"}, lhs, 32'h0);
    chk({n, "_rhs"}, rhs, 32'h0);
    chk({n, "_func"}, 32'(func), 32'h0);
    chk({n, "_alt"}, 32'(alt), 32'h0);
    chk({n, "_rd"}, 32'(out_rd), 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      r[6:0] = 7'h33;
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: ;
      endcase
    end else if (k <= 6) begin
      r[6:0] = 7'h13;
    end else if (k == 7) begin
      r[6:0] = 7'h37;
    end else if (k == 8) begin
      r[6:0] = 7'h23;
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic        ill;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [2:0]  func;
    logic        alt;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // x1=5, x2=10 when these are applied
    tbl[0]  = '{32'hFFD08193, 1'b0, 32'd5,  32'hFFFFFFFD, 3'd0, 1'b0, 5'd3};  // ADDI x3,x1,-3
    tbl[1]  = '{32'h402081B3, 1'b0, 32'd5,  32'd10,       3'd0, 1'b1, 5'd3};  // SUB x3,x1,x2
    tbl[2]  = '{32'h4070D213, 1'b0, 32'd5,  32'd7,        3'd5, 1'b1, 5'd4};  // SRAI x4,x1,7
    tbl[3]  = '{32'h002082B3, 1'b0, 32'd5,  32'd10,       3'd0, 1'b0, 5'd5};  // ADD x5,x1,x2
    tbl[4]  = '{32'h00209333, 1'b0, 32'd5,  32'd10,       3'd1, 1'b0, 5'd6};  // SLL x6,x1,x2
    tbl[5]  = '{32'h4020D3B3, 1'b0, 32'd5,  32'd10,       3'd5, 1'b1, 5'd7};  // SRA x7,x1,x2
    tbl[6]  = '{32'h0020F433, 1'b0, 32'd5,  32'd10,       3'd7, 1'b0, 5'd8};  // AND x8,x1,x2
    tbl[7]  = '{32'h00309493, 1'b0, 32'd5,  32'd3,        3'd1, 1'b0, 5'd9};  // SLLI x9,x1,3
    tbl[8]  = '{32'h7FF16513, 1'b0, 32'd10, 32'h000007FF, 3'd6, 1'b0, 5'd10}; // ORI x10,x2,0x7FF
    tbl[9]  = '{32'hFFF0C593, 1'b0, 32'd5,  32'hFFFFFFFF, 3'd4, 1'b0, 5'd11}; // XORI x11,x1,-1
    tbl[10] = '{32'hABCDE637, 1'b0, 32'd0,  32'hABCDE000, 3'd0, 1'b0, 5'd12}; // LUI x12
    tbl[11] = '{32'h00208033, 1'b0, 32'd5,  32'd10,       3'd0, 1'b0, 5'd0};  // ADD x0,x1,x2
    tbl[12] = '{32'h00000000, 1'b1, 32'd0,  32'd0,        3'd0, 1'b0, 5'd0};  // all-zero word
    tbl[13] = '{32'h40209333, 1'b1, 32'd0,  32'd0,        3'd0, 1'b0, 5'd0};  // SLL with alt funct7
    tbl[14] = '{32'h022081B3, 1'b1, 32'd0,  32'd0,        3'd0, 1'b0, 5'd0};  // MUL (M extension)
    tbl[15] = '{32'h0020A023, 1'b1, 32'd0,  32'd0,        3'd0, 1'b0, 5'd0};  // store opcode

    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, 32'h0, 1'b1, 5'd1, 32'd5);
    cycle(1'b0, 32'h0, 1'b1, 5'd2, 32'd10);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, tbl[i].ins, 1'b0, 5'd0, 32'h0);
      chk($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
      if (!tbl[i].ill) begin
        chk($sformatf("tbl%0d_lhs", i), lhs, tbl[i].lhs);
        chk($sformatf("tbl%0d_rhs", i), rhs, tbl[i].rhs);
        chk($sformatf("tbl%0d_func", i), 32'(func), 32'(tbl[i].func));
        chk($sformatf("tbl%0d_alt", i), 32'(alt), 32'(tbl[i].alt));
        chk($sformatf("tbl%0d_rd", i), 32'(out_rd), 32'(tbl[i].rd));
        if (tbl[i].rd != 5'd0) cycle(1'b0, 32'h0, 1'b1, tbl[i].rd, 32'h0);
      end else begin
        chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'h1);
      end
    end

    // Dependent issue: ADDI x5,x0,1 then ADD x6,x5,x5 stalls until x5 writes back.
    cycle(1'b1, 32'h00100293, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 32'h00528333, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 32'h00528333, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 32'h00528333, 1'b1, 5'd9, 32'h55);
    cycle(1'b1, 32'h00528333, 1'b1, 5'd5, 32'd1);
    chk("dep_valid", 32'(out_valid), 32'h1);
    chk("dep_lhs", lhs, 32'd1);
    chk("dep_rhs", rhs, 32'd1);
    chk("dep_rd", 32'(out_rd), 32'd6);
    // Release of x6 and issue of ADD x7,x6,x9 in the same cycle.
    cycle(1'b1, 32'h009303B3, 1'b1, 5'd6, 32'h22);
    chk("chain_lhs", lhs, 32'h22);
    chk("chain_rhs", rhs, 32'h55);
    chk("chain_rd", 32'(out_rd), 32'd7);
    cycle(1'b0, 32'h0, 1'b1, 5'd7, 32'h0);

    // x0 writes are dropped.
    cycle(1'b0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle(1'b1, 32'h000003B3, 1'b0, 5'd0, 32'h0);
    chk("x0_lhs", lhs, 32'h0);
    chk("x0_rhs", rhs, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 5'd7, 32'h0);

    // Reset while PENDING.
    cycle(1'b1, 32'h00100293, 1'b0, 5'd0, 32'h0);
    chk("pre_rst_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0; wb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 5'd5, 32'd9);
    cycle(1'b1, 32'h00508033, 1'b0, 5'd0, 32'h0);
    chk("postrst_x1", lhs, 32'h0);
    chk("postrst_x5", rhs, 32'd9);
    cycle(1'b1, 32'h00208433, 1'b0, 5'd0, 32'h0);
    chk("postrst_x2", rhs, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 5'd8, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic       v, we;
      logic [4:0] wrd;
      v   = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 9) < 4);
      wrd = ($urandom_range(0, 1) == 0 && m_busy) ? m_busy_rd : 5'($urandom_range(0, 31));
      cycle(v, rand_instr(), we, wrd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  in  1  instr is valid this cycle.
REQ-005 in_ready  out  1  block accepts instr this cycle; transfer occurs when in_valid && in_ready.
REQ-006 instr  in  32  RV32I instruction word.
REQ-007 out_valid  out  1  one-cycle pulse; lhs/rhs/func/alt/out_rd are valid for the ALU.
REQ-008 lhs  out  32  ALU left operand.
REQ-009 rhs  out  32  ALU right operand.
REQ-010 func  out  3  ALU function code, equal to funct3 encoding (ADD=000 ... AND=111).
REQ-011 alt  out  1  subtract or arithmetic-shift select.
REQ-012 out_rd  out  5  destination register of the issued instruction.
REQ-013 wb_en  in  1  writeback strobe from the downstream stage.
REQ-014 wb_rd  in  5  writeback register index.
REQ-015 wb_data  in  32  writeback value.
REQ-016 illegal  out  1  one-cycle pulse; the accepted instr is unsupported.

Function
REQ-017 Supported opcodes: OP (0110011), OP-IMM (0010011) and LUI (0110111); all other opcodes are illegal.
- OP: func=funct3; alt=instr[30] for funct3 000/101, else 0; illegal if funct7 is not 0000000 or 0100000 (0100000 is legal only with funct3 000/101).
REQ-018 OP operands: lhs=x[rs1], rhs=x[rs2].
REQ-019 OP-IMM operands: lhs=x[rs1], rhs=sign-extended instr[31:20].
- Shifts (funct3 001/101): rhs={27'b0, instr[24:20]}; alt=instr[30] for funct3 101 only; ADDI alt=0.
REQ-020 LUI: lhs=0, rhs={instr[31:12],12'b0}, func=000, alt=0.
REQ-021 Latency: an instruction accepted at edge N drives out_valid=1 with registered operands during cycle N+1; out_valid=0 otherwise.
REQ-022 Illegal accept: illegal=1 for one cycle; out_valid stays 0; no state changes.
REQ-023 Register file: 32x32; x0 reads 0; writes with wb_rd=0 are ignored; a write occurs at the edge where wb_en=1.
REQ-024 Same-cycle bypass: a read of rs (rs!=0) while wb_en=1 and wb_rd=rs returns wb_data.
REQ-025 Scoreboard FSM, states IDLE and PENDING.
- IDLE->PENDING on a legal accept with rd!=0; pending_rd is captured.
- PENDING->IDLE on wb_en && wb_rd==pending_rd.
- A legal accept with rd=0 stays in IDLE.
REQ-026 in_ready=1 in IDLE; in PENDING, in_ready=wb_en && (wb_rd==pending_rd), i.e. release and re-issue occur in the same cycle, with bypass supplying the operand.
REQ-027 Simultaneous release and accept with new rd!=0: the FSM stays in PENDING with the new pending_rd.
REQ-028 wb_en with wb_rd not equal to pending_rd writes the register file but does not release the scoreboard.
REQ-029 in_valid=0: no output or state change except register-file writes.

Reset
REQ-030 rst_n=0 asynchronously clears: FSM->IDLE, pending_rd=0, out_valid=0, illegal=0, lhs=rhs=0, func=0, alt=0, out_rd=0, all registers=0.
- Consequently in_ready=1 during and after reset.
REQ-031 Reset during PENDING discards the in-flight instruction; a later wb_en writes normally but releases nothing.

Structure
REQ-032 Opcode, funct3/ALU function and funct7 constants live in the shared core definitions package, also used by the ALU.
REQ-033 The register file (32x32, bypass, x0 hardwired) is the sub-module regfile; decode, the scoreboard FSM and the output registers stay in decode_issue.

Verification
REQ-034 Scenario: wb x1=5, then ADDI x2,x1,-3 -> next cycle out_valid=1, lhs=5, rhs=0xFFFFFFFD, func=000, alt=0, out_rd=2.
REQ-035 Scenario: SUB x3,x1,x2 (funct7 0100000) -> func=000, alt=1; SRAI x4,x1,7 -> rhs=7, func=101, alt=1.
REQ-036 Scenario: ADDI x5,x0,1 issued, then ADD x6,x5,x5 presented -> in_ready=0 until wb_en, wb_rd=5, wb_data=1; accepted that cycle; next cycle lhs=rhs=1.
REQ-037 Scenario: instr=0x00000000 -> illegal pulses once, out_valid=0, in_ready remains 1.
REQ-038 Scenario: wb x0=0xDEADBEEF, then ADD x7,x0,x0 -> lhs=rhs=0.
REQ-039 Scenario: rst_n pulsed low while PENDING -> in_ready=1 immediately, all outputs 0, all registers read 0.
